// File: rtl/t03_ctrl_pkg.sv
// Shared types and constants for the controller event queue: event record,
// button indices, controller-word field offsets and the emit FSM states.
package t03_ctrl_pkg;

    typedef struct packed {
        logic       player;
        logic       press;
        logic [2:0] btn;
    } event_t;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int P1_STATE_LSB = 28;
    localparam int P2_STATE_LSB = 24;
    localparam int P1_BTN_LSB   = 16;
    localparam int P2_BTN_LSB   = 8;
    localparam int BTN_LSB      = P2_BTN_LSB;
    localparam int BTN_MSB      = P1_BTN_LSB + 7;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Bit k of the 16-bit button vector: the upper byte (k >= 8) belongs to P1.
    function automatic event_t make_event(input logic [3:0] k, input logic press);
        event_t ev;
        ev.player = ~k[3];
        ev.press  = press;
        ev.btn    = k[2:0];
        return ev;
    endfunction

endpackage

// File: rtl/t03_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module t03_event_fifo
    import t03_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  event_t                 push_data,
    input  logic                   pop,
    output event_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    event_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/t03_controller_event_queue.sv
// Debounces the 16 controller buttons, converts each committed change into
// press/release events (bit 15 first) and queues them for the game logic.
module t03_controller_event_queue
    import t03_ctrl_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            packed_in,
    input  logic                   event_ready,
    output logic                   event_valid,
    output logic [4:0]             event_data,
    output logic [15:0]            buttons_stable,
    output logic [1:0]             p1_state,
    output logic [1:0]             p2_state,
    output logic [$clog2(DEPTH):0] event_count,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = STABLE_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            state;
    state_t            state_next;
    logic [15:0]       sample;
    logic [15:0]       candidate;
    logic [15:0]       cand_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [15:0]       pending;
    logic [15:0]       pending_next;
    logic [15:0]       press_mask;
    logic [15:0]       mask_next;
    logic [15:0]       stable_next;
    logic [15:0]       pending_cleared;
    logic [3:0]        top_idx;
    logic              commit;
    logic              push;
    event_t            push_data;
    event_t            head;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic              unused_bits;

    assign sample      = packed_in[BTN_MSB:BTN_LSB];
    assign unused_bits = ^{packed_in[31:30], packed_in[27:26], packed_in[7:0]};

    // The commit decision looks at the count including this cycle's sample,
    // so a change held for STABLE_CYCLES samples commits on its last sample.
    always_comb begin
        cand_next = candidate;
        cnt_next  = cnt;
        if (sample != candidate) begin
            cand_next = sample;
            cnt_next  = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_ONE;
        end
    end

    assign commit = (cnt_next == CNT_MAX) && (cand_next != buttons_stable) && (state == IDLE);

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (pending[i]) begin
                top_idx = 4'(i);
            end
        end
    end

    assign pending_cleared = pending & ~(16'h0001 << top_idx);

    always_comb begin
        state_next   = state;
        pending_next = pending;
        mask_next    = press_mask;
        stable_next  = buttons_stable;
        push         = 1'b0;
        push_data    = '0;
        case (state)
            IDLE: begin
                if (commit) begin
                    pending_next = cand_next ^ buttons_stable;
                    mask_next    = cand_next;
                    stable_next  = cand_next;
                    state_next   = EMIT;
                end
            end
            EMIT: begin
                push         = 1'b1;
                push_data    = make_event(top_idx, press_mask[top_idx]);
                pending_next = pending_cleared;
                if (pending_cleared == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            candidate      <= '0;
            cnt            <= '0;
            pending        <= '0;
            press_mask     <= '0;
            buttons_stable <= '0;
        end else begin
            state          <= state_next;
            candidate      <= cand_next;
            cnt            <= cnt_next;
            pending        <= pending_next;
            press_mask     <= mask_next;
            buttons_stable <= stable_next;
        end
    end

    assign pop  = event_valid && event_ready;
    assign drop = push && fifo_full && !pop;

    // Player state fields pass through one register so consumers see only
    // this block's outputs; overflow stays set until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_state <= '0;
            p2_state <= '0;
            overflow <= 1'b0;
        end else begin
            p1_state <= packed_in[P1_STATE_LSB +: 2];
            p2_state <= packed_in[P2_STATE_LSB +: 2];
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    t03_event_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (event_count)
    );

    assign event_valid = !fifo_empty;
    assign event_data  = head;

endmodule
